led_court_engine: RTL and testbench

Parametrised ball-and-court game core for the LED tennis/squash board. It replaces the fixed 16-LED rally logic and its external clock divider with one block that contains the per-step tick generator, rally state machine, hit windows, faults, scoring and win detection. The block sits between the board-level top (clock, buttons, mode switch) and the seven-segment score display, and drives the LED bar directly.

---
 rtl/led_court_pkg.sv | 35 +++
 rtl/court_tick_gen.sv | 41 ++++
 rtl/led_court_engine.sv | 279 +++++++++++++++++++++++++++
 tb/tb_led_court_engine.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/led_court_pkg.sv
// -----------------------------------------------------------------------------
// led_court_pkg
// Shared definitions for the LED court game core: rally state encoding,
// player index constants, default parameter values and a width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package led_court_pkg;

    typedef enum logic [2:0] {
        ST_SERVE   = 3'd0,
        ST_TO_FAR  = 3'd1,
        ST_TO_NEAR = 3'd2,
        ST_POINT   = 3'd3,
        ST_OVER    = 3'd4
    } court_state_t;

    localparam logic PLAYER0 = 1'b0;
    localparam logic PLAYER1 = 1'b1;

    localparam int unsigned DEF_NUM_LEDS     = 16;
    localparam int unsigned DEF_HIT_ZONE     = 2;
    localparam int unsigned DEF_BASE_DIV     = 50_000_000;
    localparam int unsigned DEF_MIN_DIV      = 5_000_000;
    localparam int unsigned DEF_SPEEDUP_STEP = 2_500_000;
    localparam int unsigned DEF_SCORE_W      = 8;
    localparam int unsigned DEF_WIN_SCORE    = 11;
    localparam int unsigned DEF_POINT_HOLD   = 100_000_000;

    // $clog2 that never returns zero, so a degenerate parameter still
    // yields a legal vector width.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/court_tick_gen.sv
// -----------------------------------------------------------------------------
// court_tick_gen
// Ball-step tick generator. Counts 0..period-1 and pulses o_tick for one
// cycle when the count equals period-1. i_restart forces the count back to 0
// so the next tick arrives exactly i_period cycles later.
// Ports:
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_restart  restart the count (suppresses a coincident tick)
//   i_period   step period in clk cycles (>= 1)
//   o_tick     one-cycle step pulse
// -----------------------------------------------------------------------------
module court_tick_gen
    import led_court_pkg::*;
#(
    parameter int unsigned DIV_W = clog2_min1(DEF_BASE_DIV + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_restart,
    input  logic [DIV_W-1:0] i_period,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == (i_period - DIV_W'(1)));
    assign o_tick = w_last & ~i_restart;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/led_court_engine.sv
// -----------------------------------------------------------------------------
// led_court_engine
// Ball-and-court game core for the LED tennis/squash board: button
// synchronisers, step tick generator, rally FSM, hit windows, faults,
// scoring and win detection. All outputs are registered.
// Optional feature macro: LED_COURT_SPEEDUP_EN (returns shorten the step
// period by SPEEDUP_STEP down to MIN_DIV; otherwise period stays BASE_DIV).
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   squash     mode: 0 tennis, 1 squash (sampled while serving)
//   hits[1:0]  raw player buttons, asynchronous
//   leds       court display (one-hot ball, all-on during point / game over)
//   score0/1   player scores
//   server     player serving next / serving
//   game_over  set once a score reaches WIN_SCORE
//   winner     winning player, valid while game_over
// -----------------------------------------------------------------------------
module led_court_engine
    import led_court_pkg::*;
#(
    parameter int unsigned NUM_LEDS     = DEF_NUM_LEDS,
    parameter int unsigned HIT_ZONE     = DEF_HIT_ZONE,
    parameter int unsigned BASE_DIV     = DEF_BASE_DIV,
    parameter int unsigned MIN_DIV      = DEF_MIN_DIV,
    parameter int unsigned SPEEDUP_STEP = DEF_SPEEDUP_STEP,
    parameter int unsigned SCORE_W      = DEF_SCORE_W,
    parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE,
    parameter int unsigned POINT_HOLD   = DEF_POINT_HOLD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                squash,
    input  logic [1:0]          hits,
    output logic [NUM_LEDS-1:0] leds,
    output logic [SCORE_W-1:0]  score0,
    output logic [SCORE_W-1:0]  score1,
    output logic                server,
    output logic                game_over,
    output logic                winner
);

    localparam int unsigned DIV_W  = clog2_min1(BASE_DIV + 1);
    localparam int unsigned HOLD_W = clog2_min1(POINT_HOLD);
    localparam int unsigned POS_W  = clog2_min1(NUM_LEDS);

    localparam logic [POS_W-1:0] POS_FAR   = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0] ZONE_NEAR = POS_W'(HIT_ZONE);            // pos <  this
    localparam logic [POS_W-1:0] ZONE_FAR  = POS_W'(NUM_LEDS - HIT_ZONE); // pos >= this

`ifdef LED_COURT_SPEEDUP_EN
    localparam bit SPEEDUP_ON = 1'b1;
`else
    localparam bit SPEEDUP_ON = 1'b0;
`endif

    // Button synchroniser and rising-edge detect
    logic [1:0] r_hit_s1, r_hit_s2, r_hit_d;
    logic [1:0] w_edge;

    assign w_edge = r_hit_s2 & ~r_hit_d;

    court_state_t        r_state, w_state_n;
    logic [POS_W-1:0]    r_pos, w_pos_n;
    logic [NUM_LEDS-1:0] r_leds, w_leds_n;
    logic [SCORE_W-1:0]  r_score0, w_score0_n, r_score1, w_score1_n, w_cur_score;
    logic                r_server, w_server_n;
    logic                r_over, w_over_n;
    logic                r_winner, w_winner_n;
    logic                r_scorer, w_scorer_n;
    logic                r_squash, w_squash_n;
    logic                r_hitter, w_hitter_n;
    logic [DIV_W-1:0]    r_period, w_period_n, w_period_ret;
    logic [HOLD_W-1:0]   r_hold, w_hold_n;
    logic                w_restart, w_tick;
    logic                w_recv, w_in_zone, w_at_end;
    logic                w_point, w_point_to;

    court_tick_gen #(
        .DIV_W(DIV_W)
    ) u_tick (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_restart(w_restart),
        .i_period (r_period),
        .o_tick   (w_tick)
    );

    // Guarded subtraction: only step down while the result stays above MIN_DIV.
    always_comb begin
        w_period_ret = DIV_W'(BASE_DIV);
        if (SPEEDUP_ON) begin
            if (32'(r_period) > (MIN_DIV + SPEEDUP_STEP)) begin
                w_period_ret = r_period - DIV_W'(SPEEDUP_STEP);
            end else begin
                w_period_ret = DIV_W'(MIN_DIV);
            end
        end
    end

    // Receiver, hit window and end-of-court for the current flight.
    // Squash flights toward the wall have no receiver end: the wall bounces.
    always_comb begin
        w_recv    = PLAYER0;
        w_in_zone = 1'b0;
        w_at_end  = 1'b0;
        if (r_squash) begin
            w_recv = r_hitter;
            if (r_state == ST_TO_NEAR) begin
                w_in_zone = (r_pos < ZONE_NEAR);
                w_at_end  = (r_pos == '0);
            end
        end else if (r_state == ST_TO_FAR) begin
            w_recv    = PLAYER1;
            w_in_zone = (r_pos >= ZONE_FAR);
            w_at_end  = (r_pos == POS_FAR);
        end else begin
            w_recv    = PLAYER0;
            w_in_zone = (r_pos < ZONE_NEAR);
            w_at_end  = (r_pos == '0);
        end
    end

    assign w_cur_score = (r_scorer == PLAYER0) ? r_score0 : r_score1;

    always_comb begin
        w_state_n  = r_state;
        w_pos_n    = r_pos;
        w_score0_n = r_score0;
        w_score1_n = r_score1;
        w_server_n = r_server;
        w_over_n   = r_over;
        w_winner_n = r_winner;
        w_scorer_n = r_scorer;
        w_squash_n = r_squash;
        w_hitter_n = r_hitter;
        w_period_n = r_period;
        w_hold_n   = r_hold;
        w_restart  = 1'b0;
        w_point    = 1'b0;
        w_point_to = PLAYER0;
        w_leds_n   = '1;

        case (r_state)
            ST_SERVE: begin
                w_squash_n = squash;
                w_pos_n    = (r_server == PLAYER1 && !squash) ? POS_FAR : '0;
                if (w_edge[r_server]) begin
                    w_restart  = 1'b1;
                    w_period_n = DIV_W'(BASE_DIV);
                    w_hitter_n = ~r_server;
                    w_state_n  = (squash || r_server == PLAYER0) ? ST_TO_FAR : ST_TO_NEAR;
                end
            end

            ST_TO_FAR, ST_TO_NEAR: begin
                // A receiver edge takes priority over a coincident tick.
                if (w_edge[w_recv]) begin
                    if (w_in_zone) begin
                        w_restart  = 1'b1;
                        w_period_n = w_period_ret;
                        w_state_n  = (r_state == ST_TO_FAR) ? ST_TO_NEAR : ST_TO_FAR;
                        if (r_squash) begin
                            w_hitter_n = ~r_hitter;
                        end
                    end else begin
                        w_point    = 1'b1;
                        w_point_to = ~w_recv;
                    end
                end else if (w_tick) begin
                    if (w_at_end) begin
                        w_point    = 1'b1;
                        w_point_to = ~w_recv;
                    end else if (r_state == ST_TO_FAR) begin
                        if (r_pos == POS_FAR) begin
                            // squash wall bounce
                            w_state_n = ST_TO_NEAR;
                            w_pos_n   = r_pos - POS_W'(1);
                        end else begin
                            w_pos_n = r_pos + POS_W'(1);
                        end
                    end else begin
                        w_pos_n = r_pos - POS_W'(1);
                    end
                end
            end

            ST_POINT: begin
                if (r_hold == HOLD_W'(POINT_HOLD - 1)) begin
                    w_hold_n = '0;
                    if (w_cur_score == SCORE_W'(WIN_SCORE)) begin
                        w_state_n  = ST_OVER;
                        w_over_n   = 1'b1;
                        w_winner_n = r_scorer;
                    end else begin
                        w_state_n  = ST_SERVE;
                        w_server_n = r_scorer;
                        w_squash_n = squash;
                        w_pos_n    = (r_scorer == PLAYER1 && !squash) ? POS_FAR : '0;
                    end
                end else begin
                    w_hold_n = r_hold + HOLD_W'(1);
                end
            end

            ST_OVER: begin
            end

            default: begin
                w_state_n = ST_SERVE;
                w_pos_n   = '0;
            end
        endcase

        if (w_point) begin
            w_state_n  = ST_POINT;
            w_scorer_n = w_point_to;
            w_hold_n   = '0;
            if (w_point_to == PLAYER0) begin
                w_score0_n = r_score0 + SCORE_W'(1);
            end else begin
                w_score1_n = r_score1 + SCORE_W'(1);
            end
        end

        // LEDs follow the next state so they change on the same edge as pos.
        if (w_state_n == ST_POINT || w_state_n == ST_OVER) begin
            w_leds_n = '1;
        end else begin
            w_leds_n = NUM_LEDS'(1) << w_pos_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hit_s1 <= '0;
            r_hit_s2 <= '0;
            r_hit_d  <= '0;
            r_state  <= ST_SERVE;
            r_pos    <= '0;
            r_leds   <= NUM_LEDS'(1);
            r_score0 <= '0;
            r_score1 <= '0;
            r_server <= PLAYER0;
            r_over   <= 1'b0;
            r_winner <= PLAYER0;
            r_scorer <= PLAYER0;
            r_squash <= 1'b0;
            r_hitter <= PLAYER1;
            r_period <= DIV_W'(BASE_DIV);
            r_hold   <= '0;
        end else begin
            r_hit_s1 <= hits;
            r_hit_s2 <= r_hit_s1;
            r_hit_d  <= r_hit_s2;
            r_state  <= w_state_n;
            r_pos    <= w_pos_n;
            r_leds   <= w_leds_n;
            r_score0 <= w_score0_n;
            r_score1 <= w_score1_n;
            r_server <= w_server_n;
            r_over   <= w_over_n;
            r_winner <= w_winner_n;
            r_scorer <= w_scorer_n;
            r_squash <= w_squash_n;
            r_hitter <= w_hitter_n;
            r_period <= w_period_n;
            r_hold   <= w_hold_n;
        end
    end

    assign leds      = r_leds;
    assign score0    = r_score0;
    assign score1    = r_score1;
    assign server    = r_server;
    assign game_over = r_over;
    assign winner    = r_winner;

endmodule

// File: tb/tb_led_court_engine.sv
// -----------------------------------------------------------------------------
// tb_led_court_engine
// Directed bench for led_court_engine with an 8-LED court, BASE_DIV=4,
// MIN_DIV=2, SPEEDUP_STEP=1, WIN_SCORE=3, POINT_HOLD=8. Outputs are sampled
// 1 ns after each rising edge; a button press is held for one clock and acts
// on the third rising edge after it is applied.
// -----------------------------------------------------------------------------
module tb_led_court_engine;

`ifdef LED_COURT_SPEEDUP_EN
    localparam int PER = 3;  // period after the first return
`else
    localparam int PER = 4;
`endif

    logic       clk;
    logic       reset;
    logic       squash;
    logic [1:0] hits;
    logic [7:0] leds;
    logic [7:0] score0, score1;
    logic       server, game_over, winner;

    int n_chk = 0;
    int n_bad = 0;

    led_court_engine #(
        .NUM_LEDS    (8),
        .HIT_ZONE    (2),
        .BASE_DIV    (4),
        .MIN_DIV     (2),
        .SPEEDUP_STEP(1),
        .SCORE_W     (8),
        .WIN_SCORE   (3),
        .POINT_HOLD  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .squash   (squash),
        .hits     (hits),
        .leds     (leds),
        .score0   (score0),
        .score1   (score1),
        .server   (server),
        .game_over(game_over),
        .winner   (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [1:0] b);
        hits = b;
        cyc(1);
        hits = 2'b00;
    endtask

    task automatic wait_leds(input string tag, input logic [7:0] v, input int budget);
        int n;
        n = 0;
        while (leds !== v && n < budget) begin
            cyc(1);
            n++;
        end
        chk(tag, leds, v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1);
    end

    initial begin
        reset  = 1'b0;
        squash = 1'b0;
        hits   = 2'b00;
        cyc(3);
        chk("rst_leds", leds, 8'h01);
        chk("rst_score0", score0, 0);
        chk("rst_score1", score1, 0);
        chk("rst_server", server, 0);
        chk("rst_over", game_over, 0);
        chk("rst_winner", winner, 0);
        reset = 1'b1;
        cyc(1);

        // Rally 1: serve by 0, ignored non-receiver press, miss at far end
        press(2'b01);
        cyc(1); chk("r1_presync", leds, 8'h01);
        cyc(1); chk("r1_launch", leds, 8'h01);
        cyc(3); chk("r1_nostep", leds, 8'h01);
        cyc(1); chk("r1_step1", leds, 8'h02);
        press(2'b01);
        cyc(3); chk("r1_ign_p0", leds, 8'h04);
        cyc(19); chk("r1_pos6", leds, 8'h40);
        cyc(1); chk("r1_pos7", leds, 8'h80);
        cyc(3); chk("r1_pos7_hold", leds, 8'h80);
        chk("r1_noscore", score0, 0);
        cyc(1); chk("r1_miss_leds", leds, 8'hFF);
        chk("r1_miss_score0", score0, 1);
        cyc(7); chk("r1_flash_end", leds, 8'hFF);
        cyc(1); chk("r1_serve_leds", leds, 8'h01);
        chk("r1_server", server, 0);

        // Rally 2: fault by player 1 at pos 3
        press(2'b01);
        cyc(2); chk("r2_launch", leds, 8'h01);
        cyc(12); chk("r2_pos3", leds, 8'h08);
        press(2'b10);
        cyc(1); chk("r2_prefault", leds, 8'h08);
        cyc(1); chk("r2_fault_leds", leds, 8'hFF);
        chk("r2_score0", score0, 2);
        chk("r2_score1", score1, 0);
        cyc(7); chk("r2_flash", leds, 8'hFF);
        cyc(1); chk("r2_serve_leds", leds, 8'h01);
        chk("r2_server", server, 0);

        // Rally 3: return at pos 6, then player 0 misses
        press(2'b01);
        cyc(2); chk("r3_launch", leds, 8'h01);
        cyc(24); chk("r3_pos6", leds, 8'h40);
        press(2'b10);
        cyc(2); chk("r3_return", leds, 8'h40);
        cyc(2); chk("r3_ret_hold", leds, 8'h40);
        cyc(1); chk("r3_step_a", leds, (PER == 3) ? 8'h20 : 8'h40);
        cyc(1); chk("r3_step_b", leds, 8'h20);
        press(2'b10);
        wait_leds("r3_reach0", 8'h01, 40);
        cyc(PER - 1); chk("r3_at0", leds, 8'h01);
        cyc(1); chk("r3_miss_leds", leds, 8'hFF);
        chk("r3_score1", score1, 1);
        cyc(7); chk("r3_flash", leds, 8'hFF);
        cyc(1); chk("r3_serve_leds", leds, 8'h80);
        chk("r3_server", server, 1);

        // Rally 4: server 1, player 0 returns at pos 1, player 1 faults at pos 3
        press(2'b10);
        cyc(2); chk("r4_launch", leds, 8'h80);
        cyc(24); chk("r4_pos1", leds, 8'h02);
        press(2'b01);
        cyc(2); chk("r4_return", leds, 8'h02);
        wait_leds("r4_pos3", 8'h08, 20);
        press(2'b10);
        cyc(2); chk("r4_fault_leds", leds, 8'hFF);
        chk("r4_score0", score0, 3);
        cyc(7); chk("r4_not_over_yet", game_over, 0);
        cyc(1); chk("r4_over", game_over, 1);
        chk("r4_winner", winner, 0);
        chk("r4_over_leds", leds, 8'hFF);
        press(2'b11);
        cyc(6); chk("r4_hold_leds", leds, 8'hFF);
        chk("r4_hold_s0", score0, 3);
        chk("r4_hold_s1", score1, 1);
        chk("r4_hold_over", game_over, 1);

        // Asynchronous reset from the game-over state
        reset = 1'b0;
        #1;
        chk("rst2_leds", leds, 8'h01);
        chk("rst2_score0", score0, 0);
        chk("rst2_score1", score1, 0);
        chk("rst2_server", server, 0);
        chk("rst2_over", game_over, 0);
        chk("rst2_winner", winner, 0);
        squash = 1'b1;
        cyc(2);
        reset = 1'b1;
        cyc(1);

        // Squash rally: wall bounce, player 1 returns, then player 0 misses
        press(2'b01);
        cyc(2); chk("sq_launch", leds, 8'h01);
        cyc(28); chk("sq_pos7", leds, 8'h80);
        cyc(4); chk("sq_bounce", leds, 8'h40);
        cyc(20); chk("sq_pos1", leds, 8'h02);
        press(2'b11);
        cyc(2); chk("sq_return", leds, 8'h02);
        chk("sq_ret_s0", score0, 0);
        chk("sq_ret_s1", score1, 0);
        cyc(PER); chk("sq_away", leds, 8'h04);
        wait_leds("sq_wall2", 8'h80, 40);
        wait_leds("sq_back1", 8'h02, 60);
        press(2'b10);
        cyc(2 * PER - 1); chk("sq_miss_leds", leds, 8'hFF);
        chk("sq_miss_s1", score1, 1);
        chk("sq_miss_s0", score0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
